// File: rtl/regfile_pkg.sv
// Shared constants and address type for the multi-ported register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit tracker: a write clears the destination, a reserve sets it (reserve wins), x0 never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rsta,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR-1:0][AW-1:0]  wr_addr,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_addr,
    output logic [NREGS-1:0]        busy,
    output logic [AW:0]             busy_cnt
);

    logic [NREGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i]) busy_d[wr_addr[i]] = 1'b0;
        end
        // Applied after the clears so a new producer in the same cycle keeps the register busy.
        if (rsv_en) busy_d[rsv_addr] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    always_comb begin
        busy_cnt = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_cnt = busy_cnt + {{AW{1'b0}}, busy_q[r]};
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with busy scoreboard; x0 hardwired to zero.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rsta,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic [AW:0]              busy_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NWR-1:0]   wr_act;
    logic             rsv_act;
    logic [NREGS-1:0] busy;

    always_comb begin
        for (int i = 0; i < NWR; i++) begin
            wr_act[i] = wr_en[i] && (wr_addr[i] != AW'(ZERO_REG));
        end
        rsv_act = rsv_en && (rsv_addr != AW'(ZERO_REG));
    end

    // Ascending port order makes the highest-index writer win on address collisions.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NWR; i++) begin
            if (wr_act[i]) regs_d[wr_addr[i]] = wr_data[i];
        end
    end

    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) regs_q <= '{default: '0};
        else      regs_q <= regs_d;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rsta     (rsta),
        .wr_en    (wr_act),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_act),
        .rsv_addr (rsv_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
`ifdef REGFILE_MP_BYPASS_EN
            for (int i = 0; i < NWR; i++) begin
                if (wr_act[i] && (wr_addr[i] == rd_addr[p])) begin
                    rd_data[p] = wr_data[i];
                    rd_busy[p] = rsv_act && (rsv_addr == rd_addr[p]);
                end
            end
`endif
            if (rsta || (rd_addr[p] == AW'(ZERO_REG))) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

endmodule
